// File: rtl/bit_serial_alu.sv
// Bit-serial ALU: one 1-bit slice, LSB first, WIDTH+2 cycles per operation.
// Define BIT_SERIAL_ALU_SLT_EN to support SLT (aluCtl 0111).
module bit_serial_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inValid,
    output logic             inReady,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       aluCtl,
    output logic             outValid,
    input  logic             outReady,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             carryOut
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam logic [3:0] C_NOR = 4'b1100;
`ifdef BIT_SERIAL_ALU_SLT_EN
    localparam logic [3:0] C_SLT = 4'b0111;
`endif

    localparam logic [1:0] OP_AND = 2'd0;
    localparam logic [1:0] OP_OR  = 2'd1;
    localparam logic [1:0] OP_ADD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [3:0]       r_ctl;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_ovf;
    logic             r_cout;

    logic             w_accept;
    logic             w_last;
    logic             w_cin_init;
    logic             w_ainv;
    logic             w_binv;
    logic [1:0]       w_op;
    logic             w_arith;
    logic             w_supp;
    logic             w_ai;
    logic             w_bi;
    logic             w_sum;
    logic             w_co;
    logic             w_bit;
    logic [WIDTH-1:0] w_res_shift;
    logic [WIDTH-1:0] w_res_fin;

    assign inReady  = (r_state == IDLE);
    assign outValid = (r_state == DONE);
    assign result   = r_result;
    assign zero     = r_zero;
    assign overflow = r_ovf;
    assign carryOut = r_cout;

    assign w_accept = (r_state == IDLE) && inValid;
    assign w_last   = (r_cnt == CW'(WIDTH - 1));

`ifdef BIT_SERIAL_ALU_SLT_EN
    assign w_cin_init = (aluCtl == C_SUB) || (aluCtl == C_SLT);
`else
    assign w_cin_init = (aluCtl == C_SUB);
`endif

    always_comb begin
        w_ainv  = 1'b0;
        w_binv  = 1'b0;
        w_op    = OP_AND;
        w_arith = 1'b0;
        w_supp  = 1'b1;
        unique case (r_ctl)
            C_AND: w_op = OP_AND;
            C_OR:  w_op = OP_OR;
            C_ADD: begin
                w_op    = OP_ADD;
                w_arith = 1'b1;
            end
            C_SUB: begin
                w_op    = OP_ADD;
                w_binv  = 1'b1;
                w_arith = 1'b1;
            end
`ifdef BIT_SERIAL_ALU_SLT_EN
            C_SLT: begin
                w_op   = OP_ADD;
                w_binv = 1'b1;
            end
`endif
            C_NOR: begin
                w_op   = OP_AND;
                w_ainv = 1'b1;
                w_binv = 1'b1;
            end
            default: w_supp = 1'b0;
        endcase
    end

    // The single 1-bit slice; operands shift right so bit 0 is always current.
    assign w_ai  = r_a[0] ^ w_ainv;
    assign w_bi  = r_b[0] ^ w_binv;
    assign w_sum = w_ai ^ w_bi ^ r_carry;
    assign w_co  = (w_ai & w_bi) | (r_carry & (w_ai ^ w_bi));

    always_comb begin
        w_bit = 1'b0;
        if (w_supp) begin
            unique case (w_op)
                OP_AND:  w_bit = w_ai & w_bi;
                OP_OR:   w_bit = w_ai | w_bi;
                OP_ADD:  w_bit = w_sum;
                default: w_bit = 1'b0;
            endcase
        end
    end

    assign w_res_shift = {w_bit, r_result[WIDTH-1:1]};

`ifdef BIT_SERIAL_ALU_SLT_EN
    logic w_slt;
    logic w_set;
    assign w_slt     = (r_ctl == C_SLT);
    assign w_set     = w_sum ^ (r_carry ^ w_co);
    assign w_res_fin = w_slt ? {{(WIDTH-1){1'b0}}, w_set} : w_res_shift;
`else
    assign w_res_fin = w_res_shift;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: if (inValid) w_state_nxt = RUN;
            RUN:  if (w_last) w_state_nxt = DONE;
            DONE: if (outReady) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_ctl    <= '0;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_result <= '0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
            r_cout   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_ctl    <= aluCtl;
                r_cnt    <= '0;
                r_carry  <= w_cin_init;
                r_result <= '0;
                r_zero   <= 1'b0;
                r_ovf    <= 1'b0;
                r_cout   <= 1'b0;
            end else if (r_state == RUN) begin
                r_a     <= r_a >> 1;
                r_b     <= r_b >> 1;
                r_carry <= w_co;
                r_cnt   <= r_cnt + CW'(1);
                if (w_last) begin
                    r_result <= w_res_fin;
                    r_zero   <= (w_res_fin == '0);
                    r_ovf    <= w_arith & (r_carry ^ w_co);
                    r_cout   <= w_arith & w_co;
                end else begin
                    r_result <= w_res_shift;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_serial_alu.sv
// Randomised self-checking bench for bit_serial_alu against an arithmetic model.
module tb_bit_serial_alu;

    localparam int W = 8;
    localparam int SMAX = (1 << (W - 1)) - 1;
    localparam int SMIN = -(1 << (W - 1));

    logic         clk = 1'b0;
    logic         rst_n;
    logic         inValid;
    logic         inReady;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   aluCtl;
    logic         outValid;
    logic         outReady;
    logic [W-1:0] result;
    logic         zero;
    logic         overflow;
    logic         carryOut;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] exp_r;
    logic         exp_z;
    logic         exp_v;
    logic         exp_c;

    bit_serial_alu #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inValid(inValid),
        .inReady(inReady),
        .a(a),
        .b(b),
        .aluCtl(aluCtl),
        .outValid(outValid),
        .outReady(outReady),
        .result(result),
        .zero(zero),
        .overflow(overflow),
        .carryOut(carryOut)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t",
                     name, act, expv, $time);
        end
    endtask

    // Result {result, zero, overflow, carryOut} from plain arithmetic.
    function automatic logic [W+2:0] model(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic [3:0] c);
        logic [W:0]   s;
        logic [W-1:0] r;
        logic         v;
        logic         co;
        int           ix;
        int           iy;
        ix = $signed(x);
        iy = $signed(y);
        r = '0;
        v = 1'b0;
        co = 1'b0;
        case (c)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b1100: r = ~(x | y);
            4'b0010: begin
                s = {1'b0, x} + {1'b0, y};
                r = s[W-1:0];
                co = s[W];
                v = (ix + iy > SMAX) || (ix + iy < SMIN);
            end
            4'b0110: begin
                s = {1'b0, x} + {1'b0, ~y} + 1;
                r = s[W-1:0];
                co = s[W];
                v = (ix - iy > SMAX) || (ix - iy < SMIN);
            end
`ifdef BIT_SERIAL_ALU_SLT_EN
            4'b0111: r = (ix < iy) ? 1 : 0;
`endif
            default: r = '0;
        endcase
        return {r, (r == '0), v, co};
    endfunction

    logic         busy = 1'b0;
    logic         tracking = 1'b0;
    int           lat = 0;
    logic [W-1:0] e_r;
    logic         e_z;
    logic         e_v;
    logic         e_c;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy = 1'b0;
            tracking = 1'b0;
        end else begin
            chk("inReady", {31'd0, inReady}, {31'd0, !busy});
            if (!busy) begin
                chk("outValid_idle", {31'd0, outValid}, 32'd0);
            end else if (tracking) begin
                lat++;
                if (outValid) begin
                    chk("latency", lat, W + 1);
                    tracking = 1'b0;
                end else if (lat > W + 4) begin
                    chk("latency_timeout", lat, W + 1);
                    tracking = 1'b0;
                    busy = 1'b0;
                end
            end else begin
                chk("outValid_hold", {31'd0, outValid}, 32'd1);
            end
            if (busy && outValid) begin
                chk("result", {24'd0, result}, {24'd0, e_r});
                chk("zero", {31'd0, zero}, {31'd0, e_z});
                chk("overflow", {31'd0, overflow}, {31'd0, e_v});
                chk("carryOut", {31'd0, carryOut}, {31'd0, e_c});
                if (outReady) busy = 1'b0;
            end else if (inValid && inReady) begin
                busy = 1'b1;
                tracking = 1'b1;
                lat = 0;
                e_r = exp_r;
                e_z = exp_z;
                e_v = exp_v;
                e_c = exp_c;
            end
        end
    end

    task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                      input logic [3:0] c, input int hold);
        int n;
        {exp_r, exp_z, exp_v, exp_c} = model(ia, ib, c);
        a = ia;
        b = ib;
        aluCtl = c;
        inValid = 1'b1;
        outReady = 1'b0;
        n = 0;
        while (!inReady && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!inReady) chk("accept_timeout", n, 0);
        @(posedge clk);
        #1;
        n = 0;
        while (!outValid && n < 30) begin
            inValid = 1'($urandom_range(0, 1));
            a = W'($urandom);
            b = W'($urandom);
            aluCtl = 4'($urandom);
            outReady = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n++;
        end
        inValid = 1'b0;
        outReady = 1'b0;
        if (!outValid) chk("done_timeout", n, W);
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        outReady = 1'b1;
        @(posedge clk);
        #1;
        outReady = 1'b0;
        chk("back_idle", {31'd0, inReady}, 32'd1);
    endtask

    localparam logic [3:0] CTLS [6] = '{4'b0000, 4'b0001, 4'b0010,
                                        4'b0110, 4'b0111, 4'b1100};

    initial begin
        rst_n = 1'b0;
        inValid = 1'b0;
        outReady = 1'b0;
        a = '0;
        b = '0;
        aluCtl = '0;
        #1;
        chk("rst_inReady", {31'd0, inReady}, 32'd1);
        chk("rst_outValid", {31'd0, outValid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {29'd0, zero, overflow, carryOut}, 32'd0);

        chk("model_add", model(8'h7F, 8'h01, 4'b0010), {8'h80, 3'b010});
        chk("model_sub0", model(8'h05, 8'h05, 4'b0110), {8'h00, 3'b101});
        chk("model_subv", model(8'h80, 8'h01, 4'b0110), {8'h7F, 3'b011});
        chk("model_and", model(8'hF0, 8'h3C, 4'b0000), {8'h30, 3'b000});
        chk("model_or", model(8'hF0, 8'h3C, 4'b0001), {8'hFC, 3'b000});
        chk("model_nor", model(8'hF0, 8'h3C, 4'b1100), {8'h03, 3'b000});
`ifdef BIT_SERIAL_ALU_SLT_EN
        chk("model_slt1", model(8'h80, 8'h7F, 4'b0111), {8'h01, 3'b000});
`else
        chk("model_slt1", model(8'h80, 8'h7F, 4'b0111), {8'h00, 3'b100});
`endif
        chk("model_slt0", model(8'h7F, 8'h80, 4'b0111), {8'h00, 3'b100});

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        op(8'h7F, 8'h01, 4'b0010, 0);
        op(8'h05, 8'h05, 4'b0110, 1);
        op(8'h80, 8'h01, 4'b0110, 0);
        op(8'h80, 8'h7F, 4'b0111, 0);
        op(8'h7F, 8'h80, 4'b0111, 2);
        op(8'hF0, 8'h3C, 4'b0000, 0);
        op(8'hF0, 8'h3C, 4'b0001, 0);
        op(8'hF0, 8'h3C, 4'b1100, 0);
        op(8'hA5, 8'h5A, 4'b1111, 0);
        op(8'h12, 8'h34, 4'b0010, 5);

        a = 8'h11;
        b = 8'h22;
        aluCtl = 4'b0010;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_inReady", {31'd0, inReady}, 32'd1);
        chk("midrst_outValid", {31'd0, outValid}, 32'd0);
        chk("midrst_result", {24'd0, result}, 32'd0);
        chk("midrst_flags", {29'd0, zero, overflow, carryOut}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        op(8'hFF, 8'h01, 4'b0010, 0);

        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            if ($urandom_range(0, 7) == 0) c = 4'($urandom);
            else c = CTLS[$urandom_range(0, 5)];
            op(W'($urandom), W'($urandom), c, int'($urandom_range(0, 3)));
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bit_serial_alu.md
BIT_SERIAL_ALU -- requirements
Module: bit_serial_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port inValid  input  1  operation request present.
REQ-005 SHALL have port inReady  output  1  block can accept a request.
REQ-006 SHALL have port a  input  WIDTH  operand A, two's complement.
REQ-007 SHALL have port b  input  WIDTH  operand B, two's complement.
REQ-008 SHALL have port aluCtl  input  4  operation: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
REQ-009 SHALL have port outValid  output  1  result/flags valid.
REQ-010 SHALL have port outReady  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port zero  output  1  result equals 0.
REQ-013 SHALL have port overflow  output  1  signed overflow (ADD/SUB only).
REQ-014 SHALL have port carryOut  output  1  carry out of MSB (ADD/SUB only).

Function
REQ-015 SHALL implement FSM states IDLE, RUN, DONE; inReady = (state==IDLE); outValid = (state==DONE).
REQ-016 IDLE: on inValid=1, SHALL latch a, b, aluCtl, clear bit counter, set carry register to 1 for SUB/SLT and 0 otherwise, go to RUN.
REQ-017 RUN: SHALL compute exactly one result bit per cycle, LSB first, bit i in RUN cycle i, using one 1-bit slice (ainvert/binvert/op derived from aluCtl, carry held in a register).
REQ-018 RUN SHALL last exactly WIDTH cycles; outValid SHALL rise in the cycle after the last RUN cycle (accept edge to outValid = WIDTH+1 cycles).
REQ-019 SUB/SLT SHALL use binvert=1 with carry-in 1; NOR SHALL use ainvert=1, binvert=1, AND op.
REQ-020 overflow SHALL equal carry into MSB XOR carry out of MSB for ADD/SUB, else 0; carryOut SHALL be MSB carry for ADD/SUB, else 0.
REQ-021 SLT SHALL produce result = {WIDTH-1 zeros, set}, set = sign of (a-b) XOR overflow; overflow and carryOut reported 0.
REQ-022 zero SHALL reflect the final result value.
REQ-023 Unsupported aluCtl codes SHALL complete with normal latency, result 0, zero 1, overflow 0, carryOut 0.
REQ-024 DONE: result and flags SHALL hold stable while outValid=1 and outReady=0.
REQ-025 DONE with outReady=1 SHALL return to IDLE next cycle; no new request accepted in that same cycle (minimum WIDTH+2 cycles per operation).
REQ-026 inValid and input-bus changes during RUN/DONE SHALL be ignored.
REQ-027 outReady asserted while not in DONE SHALL have no effect.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, inReady 1, outValid 0, result 0, zero 0, overflow 0, carryOut 0, counter and carry register 0.
REQ-029 Reset asserted mid-RUN or mid-DONE SHALL discard the operation; no outValid pulse SHALL follow reset release.
REQ-030 First request SHALL be accepted on the first rising edge after rst_n deasserts.

Configuration
REQ-031 Macro BIT_SERIAL_ALU_SLT_EN defined: SLT (0111) SHALL be supported per REQ-021.
REQ-032 Macro BIT_SERIAL_ALU_SLT_EN undefined: 0111 SHALL be treated as unsupported per REQ-023; set/less logic SHALL be absent.

Verification (WIDTH=8)
REQ-033 ADD a=0x7F, b=0x01 -> outValid 9 cycles after accept, result 0x80, overflow 1, carryOut 0, zero 0.
REQ-034 SUB a=0x05, b=0x05 -> result 0x00, zero 1, overflow 0, carryOut 1; SUB a=0x80, b=0x01 -> result 0x7F, overflow 1.
REQ-035 SLT a=0x80 (-128), b=0x7F -> result 0x01 (overflow-corrected); SLT a=0x7F, b=0x80 -> 0x00; without macro -> 0x00, zero 1.
REQ-036 AND/OR/NOR a=0xF0, b=0x3C -> 0x30 / 0xFC / 0x03, overflow 0, carryOut 0.
REQ-037 outReady held 0 for 5 cycles in DONE -> result/flags stable, inReady 0; then outReady=1 -> IDLE next cycle.
REQ-038 rst_n pulsed low at RUN cycle 4 of ADD -> all outputs at reset values immediately, no outValid afterwards, next request completes correctly.
